fc_vec_loader: RTL and testbench

FC_VEC_LOADER -- requirements
Module: fc_vec_loader

---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_vec_bank.sv | 37 +++
 rtl/fc_vec_loader.sv | 158 +++++++++++++++
 tb/tb_fc_vec_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared defaults, loader state encoding and index-width helper for fc_vec_loader
package fc_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int IN_DEF    = 128;
  localparam int IDX_W     = $clog2(IN_DEF);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } ld_state_e;

  // Keeps the index at least one bit wide for degenerate IN == 1 builds.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_vec_bank.sv
// rtl/fc_vec_bank.sv - IN x WIDTH register bank with indexed write and clear-above-index
module fc_vec_bank
  import fc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IN    = IN_DEF,
  localparam int IW   = idx_width(IN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IW-1:0]    widx_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             clr_above_i,
  output logic [WIDTH-1:0] mem_o [0:IN-1]
);

  logic [WIDTH-1:0] mem_q [0:IN-1];

  // A short frame's final write also zeroes every entry above it on the same edge.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < IN; i++) begin
      if (rst_i) begin
        mem_q[i] <= '0;
      end else if (we_i) begin
        if (IW'(i) == widx_i) begin
          mem_q[i] <= wdata_i;
        end else if (clr_above_i && (IW'(i) > widx_i)) begin
          mem_q[i] <= '0;
        end
      end
    end
  end

  assign mem_o = mem_q;

endmodule

// File: rtl/fc_vec_loader.sv
// rtl/fc_vec_loader.sv - streams elements into a fully-connected layer input vector
// FC_LOADER_DBUF_EN selects the two-bank ping-pong build; single bank otherwise.
module fc_vec_loader
  import fc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IN    = IN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             frame_short
);

  localparam int            IW       = idx_width(IN);
  localparam logic [IW-1:0] IDX_LAST = IW'(IN - 1);

  ld_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          short_q, short_d;
  logic          accept;
  logic          frame_end;
  logic          early_end;
  logic          consume;

  assign accept      = s_valid && s_ready;
  assign frame_end   = accept && (s_last || (idx_q == IDX_LAST));
  assign early_end   = accept && s_last && (idx_q != IDX_LAST);
  assign consume     = x_valid && x_ready;
  assign frame_short = short_q && !rst;

`ifdef FC_LOADER_DBUF_EN

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] bank0 [0:IN-1];
  logic [WIDTH-1:0] bank1 [0:IN-1];

  // FULL means both banks hold unconsumed frames; cnt_q counts those frames.
  assign s_ready = !rst && (state_q == ST_FILL);
  assign x_valid = !rst && (cnt_q != 2'd0);

  always_comb begin
    idx_d    = idx_q;
    short_d  = early_end;
    cnt_d    = cnt_q + {1'b0, frame_end} - {1'b0, consume};
    wr_sel_d = wr_sel_q ^ frame_end;
    rd_sel_d = rd_sel_q ^ consume;
    if (accept) begin
      idx_d = frame_end ? '0 : idx_q + IW'(1);
    end
    state_d = (cnt_d == 2'd2) ? ST_FULL : ST_FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      idx_q    <= '0;
      short_q  <= 1'b0;
      cnt_q    <= 2'd0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      short_q  <= short_d;
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  fc_vec_bank #(
    .WIDTH(WIDTH),
    .IN   (IN)
  ) u_bank0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (accept && !wr_sel_q),
    .widx_i     (idx_q),
    .wdata_i    (s_data),
    .clr_above_i(early_end),
    .mem_o      (bank0)
  );

  fc_vec_bank #(
    .WIDTH(WIDTH),
    .IN   (IN)
  ) u_bank1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (accept && wr_sel_q),
    .widx_i     (idx_q),
    .wdata_i    (s_data),
    .clr_above_i(early_end),
    .mem_o      (bank1)
  );

  always_comb begin
    for (int i = 0; i < IN; i++) begin
      x[i] = rd_sel_q ? bank1[i] : bank0[i];
    end
  end

`else

  assign s_ready = !rst && (state_q == ST_FILL);
  assign x_valid = !rst && (state_q == ST_FULL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    short_d = early_end;
    if (accept) begin
      idx_d = frame_end ? '0 : idx_q + IW'(1);
    end
    case (state_q)
      ST_FILL: if (frame_end) state_d = ST_FULL;
      ST_FULL: if (consume)   state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      short_q <= short_d;
    end
  end

  fc_vec_bank #(
    .WIDTH(WIDTH),
    .IN   (IN)
  ) u_bank0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (accept),
    .widx_i     (idx_q),
    .wdata_i    (s_data),
    .clr_above_i(early_end),
    .mem_o      (x)
  );

`endif

endmodule

// File: tb/tb_fc_vec_loader.sv
// tb/tb_fc_vec_loader.sv - scoreboard bench for fc_vec_loader, single-bank or FC_LOADER_DBUF_EN build
module tb_fc_vec_loader;

  localparam int WIDTH = 8;
  localparam int IN    = 128;
`ifdef FC_LOADER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef logic [IN*8-1:0] frame_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready = 1'b0;
  logic             frame_short;

  int     n_chk = 0;
  int     n_fail = 0;
  int     short_exp = 0;
  int     short_seen = 0;
  int     stalls = 0;
  bit     xr_rand = 1'b0;
  frame_t exp_q[$];
  frame_t mon_e;
  int     mon_bad;

  fc_vec_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .x          (x),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .frame_short(frame_short)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int diff_count(input frame_t f);
    int bad = 0;
    for (int i = 0; i < IN; i++) begin
      if (x[i] !== f[i*8 +: 8]) bad++;
    end
    return bad;
  endfunction

  // Monitor: every handshake on the layer side retires the oldest expected frame.
  always @(negedge clk) begin
    if (frame_short === 1'b1) short_seen++;
    if (x_valid === 1'b1 && x_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_bad = -1;
        for (int i = 0; i < IN; i++) begin
          if (mon_bad < 0 && x[i] !== mon_e[i*8 +: 8]) mon_bad = i;
        end
        n_chk++;
        if (mon_bad >= 0) begin
          n_fail++;
          $display("FAIL frame_data: x[%0d] got %0h, expected %0h",
                   mon_bad, x[mon_bad], mon_e[mon_bad*8 +: 8]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (xr_rand) x_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic send_elem(input logic [7:0] d, input logic last, input bit gaps);
    int g;
    int waited;
    bit ok;
    g = (gaps && $urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
    repeat (g) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    waited  = 0;
    forever begin
      @(negedge clk);
      ok = s_ready;
      tick();
      if (ok) break;
      stalls++;
      waited++;
      if (waited > 2000) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: s_ready got %0b for %0d cycles, expected 1", s_ready, waited);
        finish_now();
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Reference: a frame of len elements is presented padded with zeros up to IN.
  task automatic send_frame(input int len, input int kind, input bit gaps);
    frame_t     e;
    logic [7:0] vals [IN];
    logic       last;
    e = '0;
    for (int i = 0; i < IN; i++) begin
      vals[i] = (kind == 0) ? 8'(i) : (kind == 1) ? 8'(i + 1) : 8'($urandom);
      if (i < len) e[i*8 +: 8] = vals[i];
    end
    exp_q.push_back(e);
    if (len < IN) short_exp++;
    for (int i = 0; i < len; i++) begin
      if (i != len - 1) last = 1'b0;
      else if (len < IN) last = 1'b1;
      else last = 1'($urandom_range(0, 1));
      send_elem(vals[i], last, gaps);
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      tick();
      w++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  function automatic int nonzero_x();
    int nz = 0;
    for (int i = 0; i < IN; i++) begin
      if (x[i] !== '0) nz++;
    end
    return nz;
  endfunction

  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    finish_now();
  end

  initial begin
    frame_t f;
    int     st0;

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_s_ready", s_ready, 32'd0);
    chk("rst_x_valid", x_valid, 32'd0);
    chk("rst_frame_short", frame_short, 32'd0);
    chk("rst_x_zero", nonzero_x(), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 32'd1);
    chk("post_rst_x_valid", x_valid, 32'd0);
    tick();

    // Full ramp frame with the layer always ready.
    x_ready = 1'b1;
    send_frame(IN, 0, 1'b0);
    @(negedge clk);
    chk("ramp_latency_x_valid", x_valid, 32'd1);
    chk("ramp_s_ready_presented", s_ready, {31'd0, DBUF});
    @(negedge clk);
    chk("ramp_consumed_x_valid", x_valid, 32'd0);
    chk("ramp_consumed_s_ready", s_ready, 32'd1);
    tick();

    // Early s_last on the tenth element.
    send_frame(10, 1, 1'b0);
    @(negedge clk);
    chk("short_pulse", frame_short, 32'd1);
    chk("short_x_valid", x_valid, 32'd1);
    @(negedge clk);
    chk("short_pulse_end", frame_short, 32'd0);
    tick();

    // Backpressure: frame held for 20 cycles.
    x_ready = 1'b0;
    send_frame(IN, 2, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      f = exp_q[0];
      chk("hold_x_valid", x_valid, 32'd1);
      chk("hold_s_ready", s_ready, {31'd0, DBUF});
      chk("hold_x_stable", diff_count(f), 32'd0);
    end
    tick();
    x_ready = 1'b1;
    wait_drain("hold_drain");

    // Reset mid-frame after 50 accepted elements.
    for (int i = 0; i < 50; i++) send_elem(8'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_x_valid", x_valid, 32'd0);
    chk("midrst_s_ready", s_ready, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_after_s_ready", s_ready, 32'd1);
    chk("midrst_after_x_valid", x_valid, 32'd0);
    chk("midrst_x_zero", nonzero_x(), 32'd0);
    tick();
    send_frame(IN, 2, 1'b0);
    wait_drain("midrst_drain");

`ifdef FC_LOADER_DBUF_EN
    // Two back-to-back frames with the layer stalled.
    x_ready = 1'b0;
    st0 = stalls;
    send_frame(IN, 2, 1'b0);
    send_frame(IN, 0, 1'b0);
    chk("dbuf_no_stall", stalls - st0, 32'd0);
    @(negedge clk);
    f = exp_q[0];
    chk("dbuf_both_full_s_ready", s_ready, 32'd0);
    chk("dbuf_x_valid", x_valid, 32'd1);
    chk("dbuf_oldest_first", diff_count(f), 32'd0);
    tick();
    x_ready = 1'b1;
    wait_drain("dbuf_drain");
`else
    st0 = stalls;
`endif

    // Random valid gaps and random layer readiness over several frames.
    xr_rand = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_frame((k == 1) ? $urandom_range(1, IN - 1) : IN, 2, 1'b1);
    end
    xr_rand = 1'b0;
    tick();
    x_ready = 1'b1;
    wait_drain("random_drain");

    repeat (3) tick();
    chk("short_pulse_count", short_seen, short_exp);
    finish_now();
  end

endmodule
